// File: rtl/capture_pkg.sv
// Purpose: shared state encoding and magnitude helper for the microphone capture buffer.
// Latency: none (types and a pure combinational function).
// Backpressure: not applicable.
package capture_pkg;

  typedef enum logic [2:0] {
    FILL,
    ARMED,
    POST,
    CALC,
    DONE
  } cap_state_e;

  // Working width of sat_abs. Callers sign-extend their DATA_W sample to this width.
  // Negating the most negative DATA_W value then gives exactly 2^(DATA_W-1), which is
  // the saturated magnitude and still fits in DATA_W unsigned bits. DATA_W must be < SAT_W.
  localparam int SAT_W = 64;

  function automatic logic [SAT_W-1:0] sat_abs(input logic signed [SAT_W-1:0] x);
    logic [SAT_W-1:0] r;
    if (x[SAT_W-1]) r = $unsigned(-x);
    else            r = $unsigned(x);
    return r;
  endfunction

endpackage

// File: rtl/capture_ram.sv
// Purpose: one channel of sample storage, DEPTH x DATA_W, one write port and one read port.
// Latency: read data registered, valid 1 cycle after rd_addr; read-during-write returns old data.
// Backpressure: none; writes are accepted whenever wr_en is high.
//
// Ports: clock/reset_n (reset clears only the read register, never the array),
//        wr_en/wr_addr/wr_data write side, rd_addr/rd_data read side.
module capture_ram #(
  parameter  int DEPTH  = 512,
  parameter  int DATA_W = 18,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) rd_data <= '0;
    else          rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/mic_capture_buffer.sv
// Purpose: multi-channel circular sample capture, threshold trigger with pre-trigger history, frozen window readout.
// Latency: data_out 1 cycle after rd_ch/read_offset; start_calc 1 cycle after the sample that completes the window.
// Backpressure: none; data_rdy strobes arriving in CALC/DONE are discarded and counted in dropped.
//
// Ports: clock, reset_n (async, active low), restart (level, re-arms), data_in/data_rdy (NUM_CH packed
//        signed samples, ch0 in LSBs), threshold (unsigned magnitude), rd_ch/read_offset -> data_out,
//        finished_calc (releases CALC), noise_detected, trig_ch, start_calc, window_valid, dropped.
module mic_capture_buffer
  import capture_pkg::*;
#(
  parameter  int NUM_CH   = 4,
  parameter  int DATA_W   = 18,
  parameter  int DEPTH    = 512,
  parameter  int PRE_TRIG = 128,
  localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     restart,
  input  logic [NUM_CH*DATA_W-1:0] data_in,
  input  logic                     data_rdy,
  input  logic [DATA_W-1:0]        threshold,
  input  logic [CH_W-1:0]          rd_ch,
  input  logic [AW-1:0]            read_offset,
  input  logic                     finished_calc,
  output logic [DATA_W-1:0]        data_out,
  output logic                     noise_detected,
  output logic [CH_W-1:0]          trig_ch,
  output logic                     start_calc,
  output logic                     window_valid,
  output logic [15:0]              dropped
);

  localparam logic [AW-1:0] ONE       = AW'(1);
  localparam logic [AW-1:0] PRE_OFS   = AW'(PRE_TRIG);
  localparam logic [AW-1:0] FILL_LAST = AW'(PRE_TRIG - 1);
  localparam logic [AW-1:0] POST_LOAD = AW'(DEPTH - PRE_TRIG - 1);

  cap_state_e        state;
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     fill_cnt;
  logic [AW-1:0]     post_cnt;
  logic [AW-1:0]     trig_ptr;
  logic [AW-1:0]     rd_addr;
  logic [CH_W-1:0]   rd_ch_q;
  logic [CH_W-1:0]   hit_ch;
  logic [NUM_CH-1:0] over;
  logic              wr_en;
  logic              trig_hit;
  logic [DATA_W-1:0] ram_q [NUM_CH];

  // Restart wins over writes so a held restart leaves the buffer untouched.
  assign wr_en = data_rdy && !restart && (state == FILL || state == ARMED || state == POST);

  // Offset 0 is the oldest sample of the window: PRE_TRIG samples before the trigger.
  assign rd_addr = trig_ptr - PRE_OFS + read_offset;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic signed [DATA_W-1:0] smp;
    logic [SAT_W-1:0]         mag_ext;

    assign smp     = data_in[g*DATA_W +: DATA_W];
    assign mag_ext = sat_abs({{(SAT_W-DATA_W){smp[DATA_W-1]}}, smp});
    assign over[g] = mag_ext > {{(SAT_W-DATA_W){1'b0}}, threshold};

    capture_ram #(
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W)
    ) u_ram (
      .clock   (clock),
      .reset_n (reset_n),
      .wr_en   (wr_en),
      .wr_addr (wr_ptr),
      .wr_data (smp),
      .rd_addr (rd_addr),
      .rd_data (ram_q[g])
    );
  end

  assign trig_hit = data_rdy && (|over);

  // Scan from the top so the lowest-index channel over threshold wins.
  always_comb begin
    hit_ch = '0;
    for (int ch = NUM_CH - 1; ch >= 0; ch--) begin
      if (over[ch]) hit_ch = CH_W'(ch);
    end
  end

  // The channel select is registered alongside the RAM read so the mux output
  // lines up with the registered RAM data and data_out keeps a 1-cycle latency.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) rd_ch_q <= '0;
    else          rd_ch_q <= rd_ch;
  end

  always_comb begin
    data_out = '0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      if (rd_ch_q == CH_W'(ch)) data_out = ram_q[ch];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state          <= FILL;
      wr_ptr         <= '0;
      fill_cnt       <= '0;
      post_cnt       <= '0;
      trig_ptr       <= '0;
      trig_ch        <= '0;
      noise_detected <= 1'b0;
      start_calc     <= 1'b0;
      window_valid   <= 1'b0;
      dropped        <= '0;
    end else if (restart) begin
      state          <= FILL;
      wr_ptr         <= '0;
      fill_cnt       <= '0;
      dropped        <= '0;
      noise_detected <= 1'b0;
      window_valid   <= 1'b0;
      start_calc     <= 1'b0;
    end else begin
      start_calc <= 1'b0;
      if (wr_en) wr_ptr <= wr_ptr + ONE;

      unique case (state)
        // No trigger test while the pre-trigger history is still filling.
        FILL: begin
          if (data_rdy) begin
            if (fill_cnt == FILL_LAST) state <= ARMED;
            else                       fill_cnt <= fill_cnt + ONE;
          end
        end
        ARMED: begin
          if (trig_hit) begin
            trig_ptr       <= wr_ptr;
            trig_ch        <= hit_ch;
            noise_detected <= 1'b1;
            post_cnt       <= POST_LOAD;
            if (POST_LOAD == '0) begin
              state        <= CALC;
              start_calc   <= 1'b1;
              window_valid <= 1'b1;
            end else begin
              state <= POST;
            end
          end
        end
        POST: begin
          if (data_rdy) begin
            post_cnt <= post_cnt - ONE;
            if (post_cnt == ONE) begin
              state        <= CALC;
              start_calc   <= 1'b1;
              window_valid <= 1'b1;
            end
          end
        end
        CALC: begin
          if (data_rdy && dropped != 16'hFFFF) dropped <= dropped + 16'd1;
          if (finished_calc) state <= DONE;
        end
        DONE: begin
          if (data_rdy && dropped != 16'hFFFF) dropped <= dropped + 16'd1;
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_mic_capture_buffer.sv
// Purpose: directed self-checking bench for mic_capture_buffer (2 channels, 16-deep window, 4 pre-trigger).
// Latency: inputs driven 1 ns after the rising edge, outputs sampled 1 ns after the rising edge.
// Backpressure: not applicable.
module tb_mic_capture_buffer;
  import capture_pkg::*;

  localparam int NUM_CH   = 2;
  localparam int DATA_W   = 18;
  localparam int DEPTH    = 16;
  localparam int PRE_TRIG = 4;

  logic                     clock = 1'b0;
  logic                     reset_n = 1'b1;
  logic                     restart = 1'b0;
  logic [NUM_CH*DATA_W-1:0] data_in = '0;
  logic                     data_rdy = 1'b0;
  logic [DATA_W-1:0]        threshold = 18'd500;
  logic [0:0]               rd_ch = '0;
  logic [3:0]               read_offset = '0;
  logic                     finished_calc = 1'b0;
  logic [DATA_W-1:0]        data_out;
  logic                     noise_detected;
  logic [0:0]               trig_ch;
  logic                     start_calc;
  logic                     window_valid;
  logic [15:0]              dropped;

  int n_checks = 0;
  int n_pass   = 0;

  mic_capture_buffer #(
    .NUM_CH   (NUM_CH),
    .DATA_W   (DATA_W),
    .DEPTH    (DEPTH),
    .PRE_TRIG (PRE_TRIG)
  ) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .restart        (restart),
    .data_in        (data_in),
    .data_rdy       (data_rdy),
    .threshold      (threshold),
    .rd_ch          (rd_ch),
    .read_offset    (read_offset),
    .finished_calc  (finished_calc),
    .data_out       (data_out),
    .noise_detected (noise_detected),
    .trig_ch        (trig_ch),
    .start_calc     (start_calc),
    .window_valid   (window_valid),
    .dropped        (dropped)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input int s0, input int s1);
    data_in  = {DATA_W'(s1), DATA_W'(s0)};
    data_rdy = 1'b1;
    tick();
    data_rdy = 1'b0;
  endtask

  task automatic do_restart();
    restart = 1'b1;
    tick();
    restart = 1'b0;
  endtask

  task automatic fill_zero();
    for (int i = 0; i < PRE_TRIG; i++) push(0, 0);
  endtask

  task automatic test_reset();
    #2 reset_n = 1'b0;
    tick();
    tick();
    n_checks++; if (data_out !== 18'd0) $display("FAIL reset_data_out: got %0d expected 0", data_out); else n_pass++;
    n_checks++; if (noise_detected !== 1'b0) $display("FAIL reset_noise: got %0b expected 0", noise_detected); else n_pass++;
    n_checks++; if (trig_ch !== 1'b0) $display("FAIL reset_trig_ch: got %0d expected 0", trig_ch); else n_pass++;
    n_checks++; if (start_calc !== 1'b0) $display("FAIL reset_start_calc: got %0b expected 0", start_calc); else n_pass++;
    n_checks++; if (window_valid !== 1'b0) $display("FAIL reset_window_valid: got %0b expected 0", window_valid); else n_pass++;
    n_checks++; if (dropped !== 16'd0) $display("FAIL reset_dropped: got %0d expected 0", dropped); else n_pass++;
    n_checks++; if (dut.state !== FILL) $display("FAIL reset_state: got %0d expected %0d", dut.state, FILL); else n_pass++;
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_fill();
    threshold = 18'd500;
    for (int i = 0; i < 3; i++) push(1000, 1000);
    n_checks++; if (dut.state !== FILL) $display("FAIL fill_state_3: got %0d expected %0d", dut.state, FILL); else n_pass++;
    push(1000, 1000);
    n_checks++; if (dut.state !== ARMED) $display("FAIL fill_state_4: got %0d expected %0d", dut.state, ARMED); else n_pass++;
    n_checks++; if (noise_detected !== 1'b0) $display("FAIL fill_no_trigger: got %0b expected 0", noise_detected); else n_pass++;
  endtask

  task automatic test_ramp();
    int  trig_k = -1;
    logic early_sc = 1'b0;
    for (int k = 0; k < 60 && trig_k < 0; k++) begin
      push(100 + 10 * k, 0);
      if (noise_detected === 1'b1) trig_k = k;
    end
    n_checks++; if (trig_k !== 41) $display("FAIL ramp_trigger_index: got %0d expected 41 (value 510)", trig_k); else n_pass++;
    n_checks++; if (trig_ch !== 1'b0) $display("FAIL ramp_trig_ch: got %0d expected 0", trig_ch); else n_pass++;
    for (int i = 1; i <= 11; i++) begin
      push(100 + 10 * (41 + i), 0);
      if (i < 11) early_sc = early_sc | start_calc | window_valid;
    end
    n_checks++; if (early_sc !== 1'b0) $display("FAIL ramp_early_start: got %0b expected 0", early_sc); else n_pass++;
    n_checks++; if (start_calc !== 1'b1) $display("FAIL ramp_start_calc: got %0b expected 1", start_calc); else n_pass++;
    n_checks++; if (window_valid !== 1'b1) $display("FAIL ramp_window_valid: got %0b expected 1", window_valid); else n_pass++;
    tick();
    n_checks++; if (start_calc !== 1'b0) $display("FAIL ramp_start_pulse_width: got %0b expected 0", start_calc); else n_pass++;
    rd_ch = 1'b0;
    for (int off = 0; off < DEPTH; off++) begin
      read_offset = 4'(off);
      tick();
      n_checks++;
      if (data_out !== DATA_W'(470 + 10 * off))
        $display("FAIL ramp_window_off%0d: got %0d expected %0d", off, data_out, 470 + 10 * off);
      else n_pass++;
    end
  endtask

  task automatic test_done();
    read_offset = 4'd15;
    tick();
    n_checks++; if (data_out !== 18'd620) $display("FAIL done_pre_read: got %0d expected 620", data_out); else n_pass++;
    finished_calc = 1'b1;
    tick();
    finished_calc = 1'b0;
    n_checks++; if (dut.state !== DONE) $display("FAIL done_state: got %0d expected %0d", dut.state, DONE); else n_pass++;
    n_checks++; if (data_out !== 18'd620) $display("FAIL done_data_out: got %0d expected 620", data_out); else n_pass++;
    for (int i = 0; i < 5; i++) push(9999, 9999);
    n_checks++; if (dropped !== 16'd5) $display("FAIL done_dropped: got %0d expected 5", dropped); else n_pass++;
    n_checks++; if (data_out !== 18'd620) $display("FAIL done_frozen: got %0d expected 620", data_out); else n_pass++;
    n_checks++; if (window_valid !== 1'b1) $display("FAIL done_window_valid: got %0b expected 1", window_valid); else n_pass++;
  endtask

  task automatic test_negative_trigger();
    do_restart();
    n_checks++; if (noise_detected !== 1'b0) $display("FAIL restart_noise: got %0b expected 0", noise_detected); else n_pass++;
    n_checks++; if (window_valid !== 1'b0) $display("FAIL restart_window_valid: got %0b expected 0", window_valid); else n_pass++;
    n_checks++; if (dropped !== 16'd0) $display("FAIL restart_dropped: got %0d expected 0", dropped); else n_pass++;
    threshold = 18'd500;
    fill_zero();
    push(0, -501);
    n_checks++; if (noise_detected !== 1'b1) $display("FAIL neg501_noise: got %0b expected 1", noise_detected); else n_pass++;
    n_checks++; if (trig_ch !== 1'b1) $display("FAIL neg501_trig_ch: got %0d expected 1", trig_ch); else n_pass++;
    do_restart();
    threshold = 18'd131071;
    fill_zero();
    push(0, 131071);
    n_checks++; if (noise_detected !== 1'b0) $display("FAIL sat_pos_equal: got %0b expected 0", noise_detected); else n_pass++;
    push(0, -131071);
    n_checks++; if (noise_detected !== 1'b0) $display("FAIL sat_neg_equal: got %0b expected 0", noise_detected); else n_pass++;
    push(0, -131072);
    n_checks++; if (noise_detected !== 1'b1) $display("FAIL sat_most_negative: got %0b expected 1", noise_detected); else n_pass++;
    n_checks++; if (trig_ch !== 1'b1) $display("FAIL sat_trig_ch: got %0d expected 1", trig_ch); else n_pass++;
  endtask

  task automatic test_equal_threshold();
    do_restart();
    threshold = 18'd500;
    fill_zero();
    push(500, -500);
    n_checks++; if (noise_detected !== 1'b0) $display("FAIL equal_500: got %0b expected 0", noise_detected); else n_pass++;
    push(-600, 600);
    n_checks++; if (noise_detected !== 1'b1) $display("FAIL both_over_noise: got %0b expected 1", noise_detected); else n_pass++;
    n_checks++; if (trig_ch !== 1'b0) $display("FAIL both_over_lowest_ch: got %0d expected 0", trig_ch); else n_pass++;
  endtask

  task automatic test_restart_mid_post();
    logic sc_seen = 1'b0;
    push(0, 0);
    push(0, 0);
    n_checks++; if (dut.state !== POST) $display("FAIL midpost_pre_state: got %0d expected %0d", dut.state, POST); else n_pass++;
    data_in       = {18'd9999, 18'd9999};
    data_rdy      = 1'b1;
    finished_calc = 1'b1;
    restart       = 1'b1;
    tick();
    data_rdy      = 1'b0;
    finished_calc = 1'b0;
    restart       = 1'b0;
    n_checks++; if (dut.state !== FILL) $display("FAIL midpost_state: got %0d expected %0d", dut.state, FILL); else n_pass++;
    n_checks++; if (noise_detected !== 1'b0) $display("FAIL midpost_noise: got %0b expected 0", noise_detected); else n_pass++;
    n_checks++; if (dut.wr_ptr !== 4'd0) $display("FAIL midpost_wr_ptr: got %0d expected 0", dut.wr_ptr); else n_pass++;
    restart  = 1'b1;
    data_rdy = 1'b1;
    repeat (3) begin
      tick();
      sc_seen = sc_seen | start_calc;
    end
    restart  = 1'b0;
    data_rdy = 1'b0;
    n_checks++; if (dut.wr_ptr !== 4'd0) $display("FAIL restart_hold_wr_ptr: got %0d expected 0", dut.wr_ptr); else n_pass++;
    for (int i = 0; i < 20; i++) begin
      push(0, 0);
      sc_seen = sc_seen | start_calc;
    end
    n_checks++; if (sc_seen !== 1'b0) $display("FAIL midpost_no_start_calc: got %0b expected 0", sc_seen); else n_pass++;
    n_checks++; if (dut.state !== ARMED) $display("FAIL midpost_rearmed: got %0d expected %0d", dut.state, ARMED); else n_pass++;
  endtask

  task automatic test_async_reset();
    do_restart();
    threshold = 18'd500;
    fill_zero();
    push(0, 1000);
    push(0, 0);
    push(0, 0);
    rd_ch       = 1'b1;
    read_offset = 4'd4;
    tick();
    n_checks++; if (noise_detected !== 1'b1) $display("FAIL async_pre_noise: got %0b expected 1", noise_detected); else n_pass++;
    #2 reset_n = 1'b0;
    #1;
    n_checks++; if (data_out !== 18'd0) $display("FAIL async_data_out: got %0d expected 0", data_out); else n_pass++;
    n_checks++; if (noise_detected !== 1'b0) $display("FAIL async_noise: got %0b expected 0", noise_detected); else n_pass++;
    n_checks++; if (trig_ch !== 1'b0) $display("FAIL async_trig_ch: got %0d expected 0", trig_ch); else n_pass++;
    n_checks++; if (start_calc !== 1'b0) $display("FAIL async_start_calc: got %0b expected 0", start_calc); else n_pass++;
    n_checks++; if (window_valid !== 1'b0) $display("FAIL async_window_valid: got %0b expected 0", window_valid); else n_pass++;
    n_checks++; if (dropped !== 16'd0) $display("FAIL async_dropped: got %0d expected 0", dropped); else n_pass++;
    tick();
    reset_n   = 1'b1;
    threshold = 18'd131071;
    for (int i = 0; i < 20; i++) push(10 * i, 0);
    n_checks++; if (dut.wr_ptr !== 4'd4) $display("FAIL wrap_wr_ptr: got %0d expected 4", dut.wr_ptr); else n_pass++;
    threshold = 18'd500;
    push(0, 700);
    n_checks++; if (trig_ch !== 1'b1) $display("FAIL wrap_trig_ch: got %0d expected 1", trig_ch); else n_pass++;
    for (int i = 0; i <= 10; i++) push(0, 800 + i);
    n_checks++; if (start_calc !== 1'b1) $display("FAIL wrap_start_calc: got %0b expected 1", start_calc); else n_pass++;
    rd_ch = 1'b0; read_offset = 4'd0; tick();
    n_checks++; if (data_out !== 18'd160) $display("FAIL wrap_ch0_off0: got %0d expected 160", data_out); else n_pass++;
    read_offset = 4'd3; tick();
    n_checks++; if (data_out !== 18'd190) $display("FAIL wrap_ch0_off3: got %0d expected 190", data_out); else n_pass++;
    rd_ch = 1'b1; read_offset = 4'd4; tick();
    n_checks++; if (data_out !== 18'd700) $display("FAIL wrap_ch1_off4: got %0d expected 700", data_out); else n_pass++;
    read_offset = 4'd15; tick();
    n_checks++; if (data_out !== 18'd810) $display("FAIL wrap_ch1_off15: got %0d expected 810", data_out); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_ramp();
    test_done();
    test_negative_trigger();
    test_equal_threshold();
    test_restart_mid_post();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at 100000 ns, expected completion");
    $fatal(1);
  end

endmodule
